// File: rtl/rv32im_pkg.sv
// Shared RV32IM divide definitions: funct3 encodings, divider FSM states and XLEN.
package rv32im_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FN_DIV  = 3'b100;
  localparam logic [2:0] FN_DIVU = 3'b101;
  localparam logic [2:0] FN_REM  = 3'b110;
  localparam logic [2:0] FN_REMU = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_CALC   = 3'd2,
    ST_FIX    = 3'd3,
    ST_FINISH = 3'd4
  } div_state_e;

  // Only funct3[1:0] distinguish the four divide ops.
  function automatic logic op_is_signed(logic [1:0] fn);
    return ~fn[0];
  endfunction

  function automatic logic op_is_rem(logic [1:0] fn);
    return fn[1];
  endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring shift-subtract divider core on unsigned magnitudes; one quotient bit per step.
module div_datapath #(
  parameter int XLEN = rv32im_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   part;
  logic [XLEN:0]   diff;

  // The dividend shifts out of quo_q from the top while quotient bits enter at the bottom.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    part  = {rem_q, quo_q[XLEN-1]};
    diff  = part - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = part[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/div_sequencer.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer with flush and special-case fast paths.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_sequencer
  import rv32im_pkg::*;
#(
  parameter int XLEN = rv32im_pkg::XLEN
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      DIV_OP,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic            FLUSH,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE,
  output logic            STALL
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d;

  logic            dp_load, dp_step;
  logic [XLEN-1:0] dp_quo, dp_rem;
  logic            sgn, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            hit;
  logic [XLEN-1:0] hit_quo, hit_rem;
  logic            op_unused;

  assign op_unused = DIV_OP[2];

  assign sgn      = op_is_signed(op_q);
  assign a_neg    = sgn & a_q[XLEN-1];
  assign b_neg    = sgn & b_q[XLEN-1];
  assign abs_a    = a_neg ? -a_q : a_q;
  assign abs_b    = b_neg ? -b_q : b_q;
  assign div_zero = (b_q == '0);
  assign ovf      = sgn & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == '1);

`ifdef DIV_RESULT_CACHE_EN
  logic            cv_q, cv_d, cs_q, cs_d;
  logic [XLEN-1:0] ca_q, ca_d, cb_q, cb_d, cq_q, cq_d, cr_q, cr_d;

  assign hit     = cv_q & (ca_q == OPERAND_A) & (cb_q == OPERAND_B)
                 & (cs_q == op_is_signed(DIV_OP[1:0]));
  assign hit_quo = cq_q;
  assign hit_rem = cr_q;

  // Both quotient and remainder are final in FINISH, so one entry serves DIV and REM alike.
  always_comb begin
    cv_d = cv_q; cs_d = cs_q; ca_d = ca_q; cb_d = cb_q; cq_d = cq_q; cr_d = cr_q;
    if (FLUSH) begin
      cv_d = 1'b0;
    end else if (state_q == ST_FINISH) begin
      cv_d = 1'b1; cs_d = sgn; ca_d = a_q; cb_d = b_q; cq_d = quo_q; cr_d = rem_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cv_q <= 1'b0; cs_q <= 1'b0; ca_q <= '0; cb_q <= '0; cq_q <= '0; cr_q <= '0;
    end else begin
      cv_q <= cv_d; cs_q <= cs_d; ca_q <= ca_d; cb_q <= cb_d; cq_q <= cq_d; cr_q <= cr_d;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_quo = '0;
  assign hit_rem = '0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          op_d = DIV_OP[1:0];
          a_d  = OPERAND_A;
          b_d  = OPERAND_B;
          if (hit) begin
            quo_d   = hit_quo;
            rem_d   = hit_rem;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        cnt_d  = CNT_W'(XLEN - 1);
        if (div_zero) begin
          quo_d   = '1;
          rem_d   = a_q;
          state_d = ST_FINISH;
        end else if (ovf) begin
          quo_d   = a_q;
          rem_d   = '0;
          state_d = ST_FINISH;
        end else begin
          dp_load = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        quo_d   = qneg_q ? -dp_quo : dp_quo;
        rem_d   = rneg_q ? -dp_rem : dp_rem;
        state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (FLUSH) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  div_datapath #(.XLEN(XLEN)) u_dp (
    .clk       (CLK),
    .rst       (RESET),
    .load      (dp_load),
    .step      (dp_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (dp_quo),
    .remainder (dp_rem)
  );

  // A flush or reset arriving in FINISH suppresses the pulse along with the result.
  assign DONE   = (state_q == ST_FINISH) & ~FLUSH & ~RESET;
  assign BUSY   = (state_q != ST_IDLE);
  assign RESULT = DONE ? (op_is_rem(op_q) ? rem_q : quo_q) : '0;
  assign STALL  = (START & (state_q == ST_IDLE))
                | (state_q == ST_INIT) | (state_q == ST_CALC) | (state_q == ST_FIX);

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed divide vectors, flush, reset, optional cache.
module tb_div_sequencer;
  import rv32im_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [2:0]  DIV_OP;
  logic [31:0] OPERAND_A, OPERAND_B;
  logic [31:0] RESULT;
  logic        BUSY, DONE, STALL;

  div_sequencer #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DIV_OP(DIV_OP),
    .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .FLUSH(FLUSH),
    .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE), .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int nvec = 0;
  int nfail = 0;
  int stall_cnt = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          t0_q[$];

`ifdef DIV_RESULT_CACHE_EN
  logic        cv = 1'b0;
  logic        cs;
  logic [31:0] ca, cb;
`endif

  // Monitor: pops one expectation per DONE pulse, checks value and latency.
  always @(negedge CLK) begin
    if (STALL) stall_cnt++;
    if (DONE) begin
      if (exp_q.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL unexpected_done: got DONE with RESULT %h, want no DONE", RESULT);
      end else begin
        logic [31:0] e;
        int l, t0;
        e = exp_q.pop_front(); l = lat_q.pop_front(); t0 = t0_q.pop_front();
        nvec++;
        if (RESULT !== e) begin
          nfail++;
          $display("FAIL result: got %h, want %h", RESULT, e);
        end
        nvec++;
        if (cyc - t0 != l) begin
          nfail++;
          $display("FAIL latency: got %0d, want %0d (result %h)", cyc - t0, l, e);
        end
      end
    end else begin
      nvec++;
      if (RESULT !== 32'h0) begin
        nfail++;
        $display("FAIL result_idle_zero: got %h, want 00000000", RESULT);
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((BUSY !== 1'b0 || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    nvec++;
    if (n >= 300) begin
      nfail++;
      $display("FAIL idle_timeout: got BUSY %b with %0d pending, want idle", BUSY, exp_q.size());
      exp_q.delete(); lat_q.delete(); t0_q.delete();
    end
  endtask

  task automatic cache_clear();
`ifdef DIV_RESULT_CACHE_EN
    cv = 1'b0;
`endif
  endtask

  // lat is the hand-computed cacheless latency; a modelled cache hit shortens it to 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want, input int lat);
    int l = lat;
    wait_idle();
`ifdef DIV_RESULT_CACHE_EN
    if (cv && ca == a && cb == b && cs == ~op[0]) l = 1;
    cv = 1'b1; ca = a; cb = b; cs = ~op[0];
`endif
    START = 1'b1; DIV_OP = op; OPERAND_A = a; OPERAND_B = b;
    exp_q.push_back(want); lat_q.push_back(l); t0_q.push_back(cyc);
    tick();
    START = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
    DIV_OP = FN_DIV; OPERAND_A = '0; OPERAND_B = '0;
    repeat (3) tick();
    @(negedge CLK);
    check("reset_busy", {31'b0, BUSY}, 32'h0);
    check("reset_done", {31'b0, DONE}, 32'h0);
    check("reset_stall", {31'b0, STALL}, 32'h0);
    check("reset_result", RESULT, 32'h0);
    tick();
    RESET = 1'b0;
    tick();

    stall_cnt = 0;
    issue(FN_DIV, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 35);
    wait_idle();
    check("stall_cycles", stall_cnt, 32'd35);
    issue(FN_REM,  32'd20, 32'hFFFFFFFD, 32'h00000002, 35);

    issue(FN_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 2);
    issue(FN_REMU, 32'd7, 32'd0, 32'h00000007, 2);
    issue(FN_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    issue(FN_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);
    issue(FN_DIV,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 2);
    issue(FN_REM,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 2);
    issue(FN_DIV,  32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 35);
    issue(FN_REM,  32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 35);
    issue(FN_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 35);
    issue(FN_REMU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 35);

    // Flush in the 10th CALC cycle: START cycle c, INIT c+1, CALC from c+2.
    wait_idle();
    START = 1'b1; DIV_OP = FN_DIVU; OPERAND_A = 32'd1000; OPERAND_B = 32'd3;
    tick();
    START = 1'b0;
    repeat (10) tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    cache_clear();
    @(negedge CLK);
    check("flush_busy", {31'b0, BUSY}, 32'h0);
    check("flush_done", {31'b0, DONE}, 32'h0);
    tick();

    // START while busy must be ignored.
    issue(FN_DIVU, 32'd100, 32'd7, 32'd14, 35);
    repeat (5) tick();
    START = 1'b1; DIV_OP = FN_DIVU; OPERAND_A = 32'd5; OPERAND_B = 32'd1;
    tick();
    START = 1'b0;

    issue(FN_DIV, 32'd100, 32'd7, 32'd14, 35);
    issue(FN_REM, 32'd100, 32'd7, 32'd2, 35);

    // Reset while in CALC.
    wait_idle();
    START = 1'b1; DIV_OP = FN_DIV; OPERAND_A = 32'd1000; OPERAND_B = 32'd3;
    tick();
    START = 1'b0;
    repeat (4) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    cache_clear();
    @(negedge CLK);
    check("rst_mid_busy", {31'b0, BUSY}, 32'h0);
    check("rst_mid_done", {31'b0, DONE}, 32'h0);
    check("rst_mid_stall", {31'b0, STALL}, 32'h0);
    check("rst_mid_result", RESULT, 32'h0);
    tick();
    issue(FN_DIV, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 35);
    wait_idle();
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the operand and result width in bits.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port START, input, 1, a request to begin a divide/remainder operation.
REQ-005 The block SHALL have port DIV_OP, input, 3, the M-extension funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have port OPERAND_A, input, XLEN, the dividend.
REQ-007 The block SHALL have port OPERAND_B, input, XLEN, the divisor.
REQ-008 The block SHALL have port FLUSH, input, 1, a pipeline flush that aborts the in-flight operation.
REQ-009 The block SHALL have port RESULT, output, XLEN, the quotient or remainder; valid only while DONE=1.
REQ-010 The block SHALL have port BUSY, output, 1, high when state is not IDLE.
REQ-011 The block SHALL have port DONE, output, 1, a one-cycle pulse marking RESULT valid.
REQ-012 The block SHALL have port STALL, output, 1, the pipeline hold request.

Function
REQ-013 The FSM SHALL have the states IDLE, INIT, CALC, FIX and FINISH.
REQ-014 START SHALL be sampled only in IDLE: DIV_OP and operands are latched, and the next state is INIT.
REQ-015 START in any other state SHALL be ignored.
REQ-016 INIT SHALL form the absolute values of the operands (signed ops only), record the result sign, load a 5-bit iteration counter with 31 and enter CALC.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle for 32 cycles; counter decrements and exits to FIX after the step at count 0.
REQ-018 FIX SHALL apply sign correction: quotient negated if operand signs differ; remainder takes the dividend sign.
REQ-019 FINISH SHALL assert DONE for exactly one cycle, then return to IDLE.
REQ-020 Normal latency SHALL be: START sampled at edge t -> DONE high in the cycle after edge t+35.
REQ-021 Divisor zero SHALL be detected in INIT and go directly to FINISH: quotient 0xFFFFFFFF, remainder = dividend, DONE in the cycle after edge t+2.
REQ-022 Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM) SHALL take the same fast path: quotient 0x80000000, remainder 0.
REQ-023 STALL SHALL equal (START & IDLE) | (state in INIT, CALC, FIX), computed combinationally; STALL=0 in FINISH so the pipeline advances with RESULT.
REQ-024 FLUSH in any state SHALL force IDLE on the next edge with no DONE; FLUSH has priority over START in the same cycle.
REQ-025 RESULT SHALL be 0 whenever DONE=0.

Reset
REQ-026 RESET SHALL set state IDLE, counter 0, all internal registers 0, and BUSY=0, DONE=0, STALL=0, RESULT=0.
REQ-027 RESET asserted mid-operation SHALL abandon the operation on that edge with no DONE, and RESET SHALL take priority over FLUSH and START.

Configuration
REQ-028 Macro DIV_RESULT_CACHE_EN SHALL enable a one-entry cache of {OPERAND_A, OPERAND_B, signedness, quotient, remainder}, filled at FINISH.
REQ-029 With DIV_RESULT_CACHE_EN, a START whose operands and signedness match a valid entry SHALL go IDLE -> FINISH directly, DONE in the cycle after edge t+1, returning the quotient or remainder per DIV_OP.
REQ-030 FLUSH and RESET SHALL invalidate the cache entry.
REQ-031 Without DIV_RESULT_CACHE_EN, no cache storage SHALL exist and every operation SHALL follow REQ-020 to REQ-022.

Structure
REQ-032 Shared package rv32im_pkg SHALL hold the DIV_OP funct3 encodings, the FSM state encodings and XLEN.
REQ-033 The iterative shift-subtract core SHALL be the sub-module div_datapath.
REQ-034 div_sequencer SHALL own the FSM, the counter, the special-case detection and the cache.

Verification
REQ-035 Signed divide: DIV 20 / 0xFFFFFFFD -> RESULT 0xFFFFFFFA, DONE 35 cycles after START, STALL high for 35 cycles; REM with the same operands -> 0x00000002.
REQ-036 Divide by zero: DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 0x00000007; both with DONE 2 cycles after START.
REQ-037 Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; latency 2.
REQ-038 Flush: FLUSH in the 10th CALC cycle -> BUSY=0 next cycle, no DONE pulse; a following DIVU 100/7 -> 14 with normal latency.
REQ-039 Cache: DIV 100/7 then REM 100/7 -> 14 then 2; with DIV_RESULT_CACHE_EN the second DONE comes 1 cycle after START, without it 35 cycles.
REQ-040 Reset: RESET in CALC -> all outputs 0 next cycle, no DONE; START in the following cycle is accepted.
